// File: rtl/instr_mem_banked_pkg.sv
// Shared types, defaults and the address legality check for the banked instruction memory.
package instr_mem_pkg;

  localparam int unsigned DEF_WORD_BYTES  = 4;
  localparam int unsigned DEF_DEPTH_BYTES = 1024;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam logic [31:0] DEF_FILL_WORD   = 32'hE000_0000;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Word-aligned and the whole word lies inside the array; done in 64 bits so addr+WORD_BYTES cannot wrap.
  function automatic logic word_access_ok(input logic [63:0] addr,
                                          input int unsigned word_bytes,
                                          input int unsigned depth_bytes);
    logic [63:0] off_mask;
    logic [63:0] last_base;
    off_mask  = 64'(word_bytes) - 64'd1;
    last_base = 64'(depth_bytes) - 64'(word_bytes);
    return ((addr & off_mask) == 64'd0) && (addr <= last_base);
  endfunction

endpackage

// File: rtl/instr_mem_banked_if.sv
// Fetch and program port bundle between the IF stage / boot path and the instruction memory.
interface instr_mem_banked_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = 4
);

  logic                    fetch_req;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    fetch_ready;
  logic                    fetch_valid;
  logic [8*WORD_BYTES-1:0] fetch_data;
  logic                    fetch_err;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [8*WORD_BYTES-1:0] wr_data;
  logic [WORD_BYTES-1:0]   wr_be;
  logic                    wr_err;
  logic                    init_done;

  modport master (
    output fetch_req, fetch_addr, wr_en, wr_addr, wr_data, wr_be,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, wr_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, wr_en, wr_addr, wr_data, wr_be,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, wr_err, init_done
  );

endinterface

// File: rtl/instr_mem_banked_init_seq.sv
// Post-reset fill sequencer: walks every word once, then parks in READY until the next reset.
module instr_mem_init_seq
  import instr_mem_pkg::*;
#(
  parameter int unsigned WORDS      = 256,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned BYTE_IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_we,
  output logic [BYTE_IDX_W-1:0] init_addr,
  output logic                  ready
);

  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned OFF_W = $clog2(WORD_BYTES);

  init_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        if (count_q == CNT_W'(WORDS - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        count_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign init_we   = (state_q == INIT);
  assign init_addr = BYTE_IDX_W'(count_q) << OFF_W;
  assign ready     = ready_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Big-endian byte-addressed instruction memory: one registered fetch port, one byte-enabled program port,
// filled with FILL_WORD after reset by instr_mem_init_seq.
module instr_mem_banked
  import instr_mem_pkg::*;
#(
  parameter int unsigned            WORD_BYTES  = DEF_WORD_BYTES,
  parameter int unsigned            DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int unsigned            ADDR_W      = DEF_ADDR_W,
  parameter logic [8*WORD_BYTES-1:0] FILL_WORD  = DEF_FILL_WORD
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_banked_if.slave  bus
);

  localparam int unsigned WORDS      = DEPTH_BYTES / WORD_BYTES;
  localparam int unsigned BYTE_IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

  logic [7:0] mem_q [DEPTH_BYTES];

  logic                  ready;
  logic                  init_we;
  logic [BYTE_IDX_W-1:0] init_addr;

  instr_mem_init_seq #(
    .WORDS      (WORDS),
    .WORD_BYTES (WORD_BYTES),
    .BYTE_IDX_W (BYTE_IDX_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  logic                  fetch_ok, wr_ok, fetch_acc, prog_we;
  logic [BYTE_IDX_W-1:0] rd_base, wr_base;
  logic [WORD_W-1:0]     rd_word, lane_data;
  logic [WORD_BYTES-1:0] lane_we;

  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [WORD_W-1:0] fetch_data_q, fetch_data_d;
  logic              wr_err_q, wr_err_d;

  // Illegal addresses are steered to byte 0 so the array is never indexed out of bounds.
  always_comb begin
    fetch_ok  = word_access_ok(64'(bus.fetch_addr), WORD_BYTES, DEPTH_BYTES);
    wr_ok     = word_access_ok(64'(bus.wr_addr), WORD_BYTES, DEPTH_BYTES);
    fetch_acc = bus.fetch_req & ready;
    prog_we   = bus.wr_en & ready & wr_ok;
    rd_base   = fetch_ok ? bus.fetch_addr[BYTE_IDX_W-1:0] : '0;
    wr_base   = init_we ? init_addr : (prog_we ? bus.wr_addr[BYTE_IDX_W-1:0] : '0);
    lane_data = init_we ? FILL_WORD : bus.wr_data;
    lane_we   = init_we ? '1 : (prog_we ? bus.wr_be : '0);
    rd_word   = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      rd_word[8*(WORD_BYTES-1-b) +: 8] = mem_q[rd_base + BYTE_IDX_W'(b)];
    end
  end

  // Storage is updated with non-blocking writes, so a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (lane_we[WORD_BYTES-1-b]) begin
        mem_q[wr_base + BYTE_IDX_W'(b)] <= lane_data[8*(WORD_BYTES-1-b) +: 8];
      end
    end
  end

  always_comb begin
    fetch_valid_d = fetch_acc;
    fetch_err_d   = fetch_acc & ~fetch_ok;
    fetch_data_d  = fetch_data_q;
    if (fetch_acc) begin
      fetch_data_d = fetch_ok ? rd_word : '0;
    end
    wr_err_d = bus.wr_en & ~(ready & wr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_data_q  <= '0;
      wr_err_q      <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_data_q  <= fetch_data_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign bus.fetch_ready = ready;
  assign bus.init_done   = ready;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.wr_err      = wr_err_q;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed plus randomized bench for instr_mem_banked (64-byte array), checked against a byte-array model.
module tb_instr_mem_banked;

  localparam int WB     = 4;
  localparam int DEPTH  = 64;
  localparam int AW     = 32;
  localparam int NWORDS = DEPTH / WB;
  localparam logic [31:0] FILL = 32'hE000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_banked_if #(.ADDR_W(AW), .WORD_BYTES(WB)) bus ();

  instr_mem_banked #(
    .WORD_BYTES  (WB),
    .DEPTH_BYTES (DEPTH),
    .ADDR_W      (AW),
    .FILL_WORD   (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [DEPTH];
  int          init_edges = 0;
  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_wr_err = 1'b0;
  int          first_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ok(input logic [31:0] a);
    return (a % 4 == 0) && (64'(a) + 64'd4 <= 64'(DEPTH));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0, 1:    return 32'(($urandom % NWORDS) * 4);
      2:       return 32'($urandom % 80);
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check_output(input string tag);
    check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(exp_valid));
    check({tag, ".err"}, 32'(bus.fetch_err), 32'(exp_err));
    check({tag, ".data"}, bus.fetch_data, exp_data);
    check({tag, ".wr_err"}, 32'(bus.wr_err), 32'(exp_wr_err));
    check({tag, ".ready"}, 32'(bus.fetch_ready), 32'(init_edges >= NWORDS));
    check({tag, ".init_done"}, 32'(bus.init_done), 32'(init_edges >= NWORDS));
  endtask

  // Called just after an edge; drives one cycle, predicts from the model, then checks after the next edge.
  task automatic apply_stimulus(input string tag, input logic freq, input logic [31:0] faddr,
                                input logic wen, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [3:0] wbe);
    bit rdy;
    bus.fetch_req  = freq;
    bus.fetch_addr = faddr;
    bus.wr_en      = wen;
    bus.wr_addr    = waddr;
    bus.wr_data    = wdata;
    bus.wr_be      = wbe;
    rdy       = (init_edges >= NWORDS);
    exp_valid = freq && rdy;
    exp_err   = exp_valid && !model_ok(faddr);
    if (exp_valid) exp_data = model_ok(faddr) ? model_word(faddr) : 32'h0;
    exp_wr_err = wen && !(rdy && model_ok(waddr));
    if (wen && rdy && model_ok(waddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[3-b]) ref_mem[int'(waddr) + b] = wdata[8*(3-b) +: 8];
      end
    end
    @(posedge clk);
    #1;
    init_edges++;
    check_output(tag);
  endtask

  task automatic idle(input string tag);
    apply_stimulus(tag, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    apply_stimulus(tag, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    apply_stimulus(tag, 1'b0, 32'h0, 1'b1, a, d, be);
  endtask

  // Asserts rst asynchronously, checks every output is cleared, then releases it just after an edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_wr_err = 1'b0; exp_data = '0;
    init_edges = 0;
    #1;
    check_output({tag, ".async"});
    @(posedge clk);
    #1;
    check_output({tag, ".held"});
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL[8*(3 - (i % 4)) +: 8];
  endtask

  task automatic run_init(input string tag);
    first_ready = 0;
    for (int i = 0; i < NWORDS + 2; i++) begin
      if (i == 3)      write({tag, ".init_wr"}, 32'h8, 32'h1234_5678, 4'hF);
      else if (i == 5) fetch({tag, ".init_fetch"}, 32'h0);
      else             idle({tag, ".init"});
      if (bus.fetch_ready && first_ready == 0) first_ready = i + 1;
    end
    check({tag, ".init_len"}, 32'(first_ready), 32'(NWORDS));
  endtask

  initial begin
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    @(posedge clk);
    #1;
    do_reset("por");
    run_init("boot");

    fetch("f_0x0", 32'h0);
    check("f_0x0.const", bus.fetch_data, FILL);
    fetch("f_0x3c", 32'h3C);
    check("f_0x3c.const", bus.fetch_data, FILL);
    fetch("f_0x8_untouched", 32'h8);
    check("f_0x8_untouched.const", bus.fetch_data, FILL);

    write("w_full", 32'h8, 32'h1122_3344, 4'b1111);
    fetch("f_full", 32'h8);
    check("f_full.const", bus.fetch_data, 32'h1122_3344);
    write("w_part", 32'h8, 32'hAABB_CCDD, 4'b0101);
    fetch("f_part", 32'h8);
    check("f_part.const", bus.fetch_data, 32'h11BB_33DD);
    idle("hold");

    fetch("f_misalign", 32'h6);
    fetch("f_range", 32'h40);
    fetch("f_wrap", 32'hFFFF_FFFC);
    check("f_wrap.err_const", 32'(bus.fetch_err), 32'd1);

    write("w_misalign", 32'h2, 32'h5555_5555, 4'hF);
    write("w_range", 32'h40, 32'h6666_6666, 4'hF);
    fetch("f_after_bad_wr", 32'h0);
    check("f_after_bad_wr.const", bus.fetch_data, FILL);
    write("w_be0", 32'h14, 32'h7777_7777, 4'h0);
    fetch("f_be0", 32'h14);

    apply_stimulus("collide", 1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("collide.old", bus.fetch_data, FILL);
    fetch("after_collide", 32'h10);
    check("after_collide.new", bus.fetch_data, 32'hDEAD_BEEF);
    apply_stimulus("parallel", 1'b1, 32'h8, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF);
    fetch("f_parallel", 32'h20);

    for (int i = 0; i < 300; i++) begin
      apply_stimulus("rand", 1'($urandom), rand_addr(), 1'($urandom), rand_addr(),
                     32'($urandom), 4'($urandom));
    end

    fetch("pre_rst_fetch", 32'h10);
    do_reset("mid_fetch_rst");
    for (int i = 0; i < 7; i++) idle("partial_init");
    do_reset("mid_init_rst");
    run_init("reinit");
    fetch("reinit_0x10", 32'h10);
    check("reinit_0x10.const", bus.fetch_data, FILL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
